// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding and sizing helpers for the iterative limb multiplier
package mul_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? clog2(n) : 1;
  endfunction
  function automatic int lat_full(input int n, input int ml);
    return n * n + ml + 1;
  endfunction
  function automatic int lat_sqr(input int n, input int ml);
    return n * (n + 1) / 2 + ml + 1;
  endfunction
endpackage

// File: rtl/mul_iter_sched_limb_mul.sv
// limb_mul: pipelined LIMB x LIMB multiplier carrying valid, offset tag and (MUL_SQR_EN) double flag
module limb_mul #(
  parameter int LIMB    = 64,
  parameter int MUL_LAT = 2,
  parameter int OW      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [LIMB-1:0]   x,
  input  logic [LIMB-1:0]   y,
  input  logic [OW-1:0]     off,
`ifdef MUL_SQR_EN
  input  logic              dbl,
  output logic              out_dbl,
`endif
  output logic              out_vld,
  output logic [2*LIMB-1:0] p,
  output logic [OW-1:0]     out_off,
  output logic              busy
);
`ifdef MUL_SQR_EN
  localparam int FW = 1;
`else
  localparam int FW = 0;
`endif
  localparam int SW = 2 * LIMB + OW + FW + 1;
  logic [2*LIMB-1:0]    prod;
  logic [SW-1:0]        in_word;
  logic [MUL_LAT*SW-1:0] pipe;
  assign prod = (2*LIMB)'(x) * (2*LIMB)'(y);
`ifdef MUL_SQR_EN
  assign in_word = {in_vld, dbl, off, prod};
  assign {out_vld, out_dbl, out_off, p} = pipe[MUL_LAT*SW-1 -: SW];
`else
  assign in_word = {in_vld, off, prod};
  assign {out_vld, out_off, p} = pipe[MUL_LAT*SW-1 -: SW];
`endif
  // shift the tagged product one stage per cycle; newest word enters at the bottom
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe <= '0;
    else pipe <= (pipe << SW) | (MUL_LAT*SW)'(in_word);
  end
  // any stage holding a valid product means results are still in flight
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < MUL_LAT; k++) busy = busy | pipe[k*SW+SW-1];
  end
endmodule

// File: rtl/mul_iter_sched.sv
// mul_iter_sched: iterative schoolbook W x W multiplier over one pipelined limb multiplier (MUL_SQR_EN adds squaring mode)
module mul_iter_sched
  import mul_pkg::*;
#(
  parameter int W       = 256,
  parameter int LIMB    = 64,
  parameter int MUL_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
`ifdef MUL_SQR_EN
  input  logic           sq,
`endif
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           ready,
  output logic           done,
  output logic [2*W-1:0] c
);
  localparam int N  = W / LIMB;
  localparam int IW = idx_w(N);
  localparam int OW = clog2(2 * N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  state_t st, nst;
  logic [W-1:0]      a_r, b_r;
  logic [IW-1:0]     i, j;
  logic [2*W-1:0]    acc, term;
  logic [2*LIMB-1:0] p;
  logic [OW-1:0]     p_off;
  logic              p_vld, busy, accept, last;
`ifdef MUL_SQR_EN
  logic sq_r, p_dbl;
`else
  localparam logic sq_r = 1'b0;
`endif
  assign ready  = st == IDLE || st == DONE;
  assign done   = st == DONE;
  assign accept = ready && start;
  assign last   = i == LAST && j == LAST;
  limb_mul #(.LIMB(LIMB), .MUL_LAT(MUL_LAT), .OW(OW)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (st == ISSUE),
    .x       (a_r[i*LIMB +: LIMB]),
    .y       (sq_r ? a_r[j*LIMB +: LIMB] : b_r[j*LIMB +: LIMB]),
    .off     (OW'(i) + OW'(j)),
`ifdef MUL_SQR_EN
    .dbl     (sq_r && i != j),
    .out_dbl (p_dbl),
`endif
    .out_vld (p_vld),
    .p       (p),
    .out_off (p_off),
    .busy    (busy)
  );
  // sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else st <= nst;
  end
  // next state: issue all pairs, then wait for the pipeline to empty before DONE
  always_comb begin
    nst = accept ? ISSUE : st == ISSUE ? (last ? DRAIN : ISSUE) : st == DRAIN ? (busy ? DRAIN : DONE) : IDLE;
  end
  // returned partial product placed at its limb offset, cross terms doubled when squaring
  always_comb begin
    term = (2*W)'(p) << (p_off * LIMB);
`ifdef MUL_SQR_EN
    term = p_dbl ? term << 1 : term;
`endif
  end
  // operand capture, pair counters, accumulator and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      i   <= '0;
      j   <= '0;
      acc <= '0;
      c   <= '0;
`ifdef MUL_SQR_EN
      sq_r <= 1'b0;
`endif
    end else if (accept) begin
      a_r <= a;
      b_r <= b;
      i   <= '0;
      j   <= '0;
      acc <= '0;
      c   <= '0;
`ifdef MUL_SQR_EN
      sq_r <= sq;
`endif
    end else begin
      if (st == ISSUE) begin
        i <= j == LAST ? i + 1'b1 : i;
        j <= j == LAST ? (sq_r ? i + 1'b1 : '0) : j + 1'b1;
      end
      if (p_vld) acc <= acc + term;
      if (st == DRAIN && !busy) c <= acc;
    end
  end
endmodule
